// File: rtl/ita_softmax_recip_div.sv
// Iterative radix-2 restoring divider: q = floor(2^DividendExp / divisor), saturated to OutWidth bits.
// One quotient bit per cycle, MSB first, with a valid/ready handshake on both sides.
//
// state | meaning
// IDLE  | waiting for a divisor, ready_o high
// CALC  | producing one quotient bit per cycle
// DONE  | quotient valid, waiting for ready_i
module ita_softmax_recip_div #(
    parameter int unsigned InWidth     = 24,
    parameter int unsigned OutWidth    = 16,
    parameter int unsigned DividendExp = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic [InWidth-1:0]  div_inp_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [OutWidth-1:0] div_oup_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o
);

    localparam int unsigned CntW = (OutWidth > 1) ? $clog2(OutWidth) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Dividend bits above the quotient window seed the remainder; any divisor
    // not larger than this seed would need more than OutWidth quotient bits.
    localparam logic [InWidth-1:0] RemInit =
        InWidth'((64'(1) << DividendExp) >> OutWidth);
    localparam logic [OutWidth-1:0] DivLow =
        (DividendExp < OutWidth) ? (OutWidth'(1) << DividendExp) : '0;

    logic [1:0]          state_q;
    logic [InWidth-1:0]  divisor_q;
    logic [InWidth-1:0]  rem_q;
    logic [OutWidth-1:0] quot_q;
    logic [CntW-1:0]     cnt_q;

    logic [InWidth:0]    rem_shift;
    logic                sub_ok;
    logic [InWidth-1:0]  rem_next;

    // The remainder always stays below the divisor, so InWidth bits hold it
    // and the shifted value needs just one extra bit.
    always_comb begin
        rem_shift = {rem_q, DivLow[cnt_q]};
        sub_ok    = (rem_shift >= {1'b0, divisor_q});
        rem_next  = sub_ok ? InWidth'(rem_shift - {1'b0, divisor_q})
                           : rem_shift[InWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
        end else if (clear_i) begin
            state_q   <= StIdle;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        divisor_q <= div_inp_i;
                        cnt_q     <= CntW'(OutWidth - 1);
                        if (div_inp_i == '0 || div_inp_i <= RemInit) begin
                            quot_q  <= '1;
                            rem_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            quot_q  <= '0;
                            rem_q   <= RemInit;
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q         <= rem_next;
                    quot_q[cnt_q] <= sub_ok;
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o   = (state_q == StIdle);
    assign valid_o   = (state_q == StDone);
    assign busy_o    = (state_q != StIdle);
    assign div_oup_o = quot_q;

endmodule

// File: tb/tb_ita_softmax_recip_div.sv
// Self-checking bench for ita_softmax_recip_div: directed cases, saturation, backpressure,
// clear, reset, random sweep against floor(2^16/D), and back-to-back issue spacing.
module tb_ita_softmax_recip_div;

    localparam int IW = 24;
    localparam int OW = 16;
    localparam int DE = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [IW-1:0] div_inp_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [OW-1:0] div_oup_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    ita_softmax_recip_div #(
        .InWidth(IW), .OutWidth(OW), .DividendExp(DE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .div_inp_i(div_inp_i), .valid_i(valid_i), .ready_o(ready_o),
        .div_oup_o(div_oup_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: plain integer division of 2^DE, clipped to the output range.
    function automatic logic [OW-1:0] ref_q(input longint unsigned d);
        longint unsigned q;
        if (d == 0) return '1;
        q = (longint'(1) << DE) / d;
        if (q > ((longint'(1) << OW) - 1)) return '1;
        return q[OW-1:0];
    endfunction

    function automatic int ref_lat(input longint unsigned d);
        return (((longint'(1) << DE) / ((d == 0) ? 1 : d)) >= (longint'(1) << OW)) ? 0 : OW;
    endfunction

    // Offers d when ready, returns edges from accept to DONE (100 = timeout).
    task automatic issue(input logic [IW-1:0] d, output int lat);
        int guard;
        guard = 0;
        @(negedge clk_i);
        while (!ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        div_inp_i = d;
        valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        checks++;
        if ({ready_o, valid_o, busy_o} !== 3'b100 || div_oup_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/vld/busy=%b q=%0d, expected 100 q=0",
                     {ready_o, valid_o, busy_o}, div_oup_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b busy=%b, expected 1 0", ready_o, busy_o);
        end
    endtask

    task automatic test_directed();
        logic [IW-1:0] ds [5] = '{24'd256, 24'd1000, 24'd16384, 24'd65535, 24'd70000};
        logic [OW-1:0] qs [5] = '{16'd256, 16'd65, 16'd4, 16'd1, 16'd0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            issue(ds[i], lat);
            checks++;
            if (lat !== OW || div_oup_o !== qs[i]) begin
                errors++;
                $display("FAIL directed_D%0d: got q=%0d lat=%0d, expected q=%0d lat=%0d",
                         ds[i], div_oup_o, lat, qs[i], OW);
            end
            retire();
            checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL directed_retire_D%0d: got ready=%b valid=%b, expected 1 0",
                         ds[i], ready_o, valid_o);
            end
        end
    endtask

    task automatic test_saturate();
        logic [IW-1:0] ds [3] = '{24'd0, 24'd1, 24'd2};
        logic [OW-1:0] qs [3] = '{16'hFFFF, 16'hFFFF, 16'd32768};
        int            ls [3] = '{0, 0, OW};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(ds[i], lat);
            checks++;
            if (lat !== ls[i] || div_oup_o !== qs[i]) begin
                errors++;
                $display("FAIL saturate_D%0d: got q=%0h lat=%0d, expected q=%0h lat=%0d",
                         ds[i], div_oup_o, lat, qs[i], ls[i]);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        issue(24'd1000, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            div_inp_i = 24'($urandom_range(2, 5000));
            valid_i   = i[0];
            if (valid_o !== 1'b1 || div_oup_o !== 16'd65 || ready_o !== 1'b0) bad++;
        end
        valid_i = 1'b0;
        checks++;
        if (lat !== OW || bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: got lat=%0d unstable_cycles=%0d, expected lat=%0d 0",
                     lat, bad, OW);
        end
        retire();
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_no_second_accept: got busy=%b ready=%b, expected 0 1",
                     busy_o, ready_o);
        end
    endtask

    task automatic test_clear();
        int lat;
        int rose;
        @(negedge clk_i);
        div_inp_i = 24'd1000;
        valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        checks++;
        if ({ready_o, valid_o, busy_o} !== 3'b100 || div_oup_o !== '0) begin
            errors++;
            $display("FAIL clear_calc: got rdy/vld/busy=%b q=%0d, expected 100 q=0",
                     {ready_o, valid_o, busy_o}, div_oup_o);
        end
        rose = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (valid_o) rose++;
        end
        checks++;
        if (rose !== 0) begin
            errors++;
            $display("FAIL clear_no_result: got %0d valid cycles, expected 0", rose);
        end
        @(negedge clk_i);
        clear_i   = 1'b1;
        valid_i   = 1'b1;
        div_inp_i = 24'd5;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_blocks_accept: got busy=%b, expected 0", busy_o);
        end
        issue(24'd512, lat);
        checks++;
        if (lat !== OW || div_oup_o !== 16'd128) begin
            errors++;
            $display("FAIL clear_then_512: got q=%0d lat=%0d, expected q=128 lat=%0d",
                     div_oup_o, lat, OW);
        end
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || div_oup_o !== '0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: got valid=%b q=%0d ready=%b, expected 0 0 1",
                     valid_o, div_oup_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(24'd300, lat);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({ready_o, valid_o, busy_o} !== 3'b100 || div_oup_o !== '0) begin
            errors++;
            $display("FAIL reset_in_done: got rdy/vld/busy=%b q=%0d, expected 100 q=0",
                     {ready_o, valid_o, busy_o}, div_oup_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        logic [IW-1:0] d;
        int lat;
        for (int i = 0; i < 40; i++) begin
            case (i % 3)
                0:       d = IW'($urandom_range(0, (1 << IW) - 1));
                1:       d = IW'($urandom_range(0, 600));
                default: d = IW'($urandom_range(60000, 70000));
            endcase
            issue(d, lat);
            checks++;
            if (div_oup_o !== ref_q(64'(d)) || lat !== ref_lat(64'(d))) begin
                errors++;
                $display("FAIL random_D%0d: got q=%0d lat=%0d, expected q=%0d lat=%0d",
                         d, div_oup_o, lat, ref_q(64'(d)), ref_lat(64'(d)));
            end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        int vo_seen;
        int bad_q;
        int guard;
        vo_seen = 0;
        bad_q   = 0;
        @(negedge clk_i);
        div_inp_i = 24'd256;
        valid_i   = 1'b1;
        ready_i   = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk_i);
            if (ready_o) accepts.push_back(n);
            if (valid_o) begin
                vo_seen++;
                if (div_oup_o !== 16'd256) bad_q++;
            end
        end
        valid_i = 1'b0;
        checks++;
        if (accepts.size() !== 4 || vo_seen !== 3 || bad_q !== 0) begin
            errors++;
            $display("FAIL b2b_counts: got accepts=%0d results=%0d bad_q=%0d, expected 4 3 0",
                     accepts.size(), vo_seen, bad_q);
        end
        for (int k = 1; k < accepts.size(); k++) begin
            checks++;
            if (accepts[k] - accepts[k-1] !== OW + 2) begin
                errors++;
                $display("FAIL b2b_interval_%0d: got %0d cycles, expected %0d",
                         k, accepts[k] - accepts[k-1], OW + 2);
            end
        end
        guard = 0;
        while (!ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        ready_i = 1'b0;
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL b2b_drain: got no return to idle, expected ready within 100 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturate();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
